// File: rtl/puf_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the PUF key sequencer: FSM states, challenge width,
// LFSR feedback taps and the substitute for an all-zero seed.
package puf_pkg;

  localparam int PUF_CHAL_W = 8;

  // Feedback taps c[7], c[5], c[4], c[3] of the maximal-length 8-bit LFSR.
  localparam logic [PUF_CHAL_W-1:0] LFSR_TAPS = 8'b1011_1000;

  // An all-zero challenge would lock the LFSR, so it is replaced on start.
  localparam logic [PUF_CHAL_W-1:0] ZERO_SEED_SUB = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Seed as loaded into the challenge register on an accepted start.
  function automatic logic [PUF_CHAL_W-1:0] seed_fix(input logic [PUF_CHAL_W-1:0] s);
    return (s == '0) ? ZERO_SEED_SUB : s;
  endfunction

endpackage

// File: rtl/puf_lfsr8.sv
`timescale 1ns/1ps
// Combinational next-state function of the 8-bit Fibonacci challenge LFSR.
// Shifts left and feeds the XOR of the tapped bits into bit 0.
module puf_lfsr8
  import puf_pkg::*;
(
  input  logic [PUF_CHAL_W-1:0] cur,
  output logic [PUF_CHAL_W-1:0] nxt
);

  assign nxt = {cur[PUF_CHAL_W-2:0], ^(cur & LFSR_TAPS)};

endmodule

// File: rtl/puf_key_sequencer.sv
`timescale 1ns/1ps
// PUF key sequencer: walks an LFSR challenge sequence, lets the PUF settle,
// majority-votes VOTES response samples per challenge and shifts each voted
// bit into the key register, MSB first. Also counts bits whose votes were
// not unanimous.
module puf_key_sequencer
  import puf_pkg::*;
#(
  parameter int KEY_BITS = 32,
  parameter int SETTLE   = 2,
  parameter int VOTES    = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [PUF_CHAL_W-1:0]           seed,
  input  logic                            puf_response,
  output logic [PUF_CHAL_W-1:0]           puf_challenge,
  output logic                            busy,
  output logic                            done,
  output logic [KEY_BITS-1:0]             key,
  output logic                            key_valid,
  output logic [$clog2(KEY_BITS+1)-1:0]   unstable_cnt
);

  localparam int UNST_W    = $clog2(KEY_BITS + 1);
  // One extra value so the count can step past the last index without wrapping.
  localparam int BIT_W     = $clog2(KEY_BITS + 1);
  localparam int ONES_W    = $clog2(VOTES + 1);
  localparam int PHASE_MAX = (SETTLE > VOTES) ? SETTLE : VOTES;
  localparam int PH_W      = $clog2(PHASE_MAX + 1);

  state_t                  state;
  state_t                  state_next;
  logic [PH_W-1:0]         phase_cnt;
  logic [ONES_W-1:0]       ones_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [PUF_CHAL_W-1:0]   chal_next;

  logic settle_end;
  logic sample_end;
  logic last_bit;
  logic vote;
  logic unanimous;

  puf_lfsr8 u_lfsr (
    .cur (puf_challenge),
    .nxt (chal_next)
  );

  assign settle_end = (phase_cnt == PH_W'(SETTLE - 1));
  assign sample_end = (phase_cnt == PH_W'(VOTES - 1));
  assign last_bit   = (bit_cnt == BIT_W'(KEY_BITS - 1));
  assign vote       = (ones_cnt > ONES_W'(VOTES / 2));
  assign unanimous  = (ones_cnt == '0) || (ones_cnt == ONES_W'(VOTES));

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode: settle, sample and shift phases per key bit.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned
    // and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:   if (start)      state_next = ST_SETTLE;
      ST_SETTLE: if (settle_end) state_next = ST_SAMPLE;
      ST_SAMPLE: if (sample_end) state_next = ST_SHIFT;
      ST_SHIFT:  state_next = last_bit ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Datapath: challenge, phase/vote/bit counters, key shift register, flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      puf_challenge <= '0;
      phase_cnt     <= '0;
      ones_cnt      <= '0;
      bit_cnt       <= '0;
      key           <= '0;
      key_valid     <= 1'b0;
      unstable_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            puf_challenge <= seed_fix(seed);
            phase_cnt     <= '0;
            bit_cnt       <= '0;
            key           <= '0;
            key_valid     <= 1'b0;
            unstable_cnt  <= '0;
          end
        end

        ST_SETTLE: begin
          if (settle_end) begin
            phase_cnt <= '0;
            ones_cnt  <= '0;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end

        ST_SAMPLE: begin
          if (puf_response) ones_cnt <= ones_cnt + ONES_W'(1);
          phase_cnt <= sample_end ? '0 : phase_cnt + PH_W'(1);
        end

        ST_SHIFT: begin
          key           <= {key[KEY_BITS-2:0], vote};
          puf_challenge <= chal_next;
          bit_cnt       <= bit_cnt + BIT_W'(1);
          if (!unanimous) unstable_cnt <= unstable_cnt + UNST_W'(1);
          // Raised on the way into DONE so it is already high with done.
          if (last_bit) key_valid <= 1'b1;
        end

        default: ; // DONE: everything holds; the key stays visible.
      endcase
    end
  end

endmodule

// File: tb/tb_puf_key_sequencer.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for puf_key_sequencer. A run task builds the
// expected key from the challenge sequence and the response bits it will
// drive, pushes it to a queue, then drives the run; a monitor pops and
// compares whenever done is seen.
module tb_puf_key_sequencer;
  import puf_pkg::*;

  localparam int KEY_BITS = 32;
  localparam int SETTLE   = 2;
  localparam int VOTES    = 3;
  localparam int P        = SETTLE + VOTES + 1;   // edges per key bit
  localparam int TOTAL    = KEY_BITS * P;         // edges until DONE is entered
  localparam int UW       = $clog2(KEY_BITS + 1);

  typedef enum int {M_CONST1, M_PARITY, M_GLITCH, M_RANDOM} mode_t;

  typedef struct {
    logic [KEY_BITS-1:0] key;
    int                  unstable;
    logic [7:0]          last_chal;
    int                  done_edge;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [7:0]          seed = 8'h00;
  logic                puf_response = 1'b0;
  logic [7:0]          puf_challenge;
  logic                busy;
  logic                done;
  logic [KEY_BITS-1:0] key;
  logic                key_valid;
  logic [UW-1:0]       unstable_cnt;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int accept_edge = 0;
  int runs_checked = 0;
  int runs_pushed = 0;

  exp_t exp_q[$];
  logic [7:0] chal [0:KEY_BITS];
  logic       drv  [0:TOTAL+1];

  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_nxt;

  puf_key_sequencer #(
    .KEY_BITS (KEY_BITS),
    .SETTLE   (SETTLE),
    .VOTES    (VOTES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .seed          (seed),
    .puf_response  (puf_response),
    .puf_challenge (puf_challenge),
    .busy          (busy),
    .done          (done),
    .key           (key),
    .key_valid     (key_valid),
    .unstable_cnt  (unstable_cnt)
  );

  // Reference LFSR step for the model's challenge sequence.
  puf_lfsr8 u_model_lfsr (
    .cur (m_cur),
    .nxt (m_nxt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Build challenge sequence, response pattern and expected result of a run.
  task automatic build_model(input logic [7:0] s, input mode_t mode, output exp_t e);
    int gpos [KEY_BITS];
    int base [KEY_BITS];
    int b, off, ones;
    chal[0] = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < KEY_BITS; i++) begin
      m_cur = chal[i];
      #1;
      chal[i+1] = m_nxt;
    end
    for (int i = 0; i < KEY_BITS; i++) begin
      gpos[i] = int'($urandom_range(0, VOTES - 1));
      base[i] = int'($urandom_range(0, 1));
    end
    drv[0] = 1'b0;
    for (int k = 1; k <= TOTAL + 1; k++) begin
      b = (k - 1) / P;
      if (b >= KEY_BITS) b = KEY_BITS - 1;
      off = (k - 1) - b * P;
      case (mode)
        M_CONST1: drv[k] = 1'b1;
        M_PARITY: drv[k] = ^chal[b];
        M_GLITCH: drv[k] = (off == SETTLE + gpos[b]);
        default: begin
          if (off >= SETTLE && off < SETTLE + VOTES)
            drv[k] = base[b][0] ^ ($urandom_range(0, 3) == 0);
          else
            drv[k] = $urandom_range(0, 1) == 1;
        end
      endcase
    end
    e.key = '0;
    e.unstable = 0;
    for (int i = 0; i < KEY_BITS; i++) begin
      ones = 0;
      for (int j = 0; j < VOTES; j++) ones += int'(drv[i * P + SETTLE + 1 + j]);
      e.key = {e.key[KEY_BITS-2:0], (ones > VOTES / 2)};
      if (ones != 0 && ones != VOTES) e.unstable++;
    end
    e.last_chal = chal[KEY_BITS];
    e.done_edge = 1 + TOTAL;
  endtask

  // One run: stray_at > 0 pulses start mid-run, rst_at > 0 resets mid-run.
  task automatic run(input logic [7:0] s, input mode_t mode, input int stray_at, input int rst_at);
    exp_t e;
    build_model(s, mode, e);
    if (rst_at == 0) begin
      exp_q.push_back(e);
      runs_pushed++;
    end
    @(negedge clk);
    start = 1'b1;
    seed = s;
    puf_response = 1'b0;
    @(posedge clk);
    #1;
    accept_edge = edge_cnt;
    check("busy_after_start", busy, 1'b1);
    check("key_valid_cleared", key_valid, 1'b0);
    check("key_cleared", key, '0);
    for (int k = 1; k <= TOTAL + 1; k++) begin
      @(negedge clk);
      start = (k == stray_at);
      if (k == stray_at) seed = 8'h3C;
      puf_response = drv[k];
      if ((k - 1) % P == 0 && (k - 1) / P < KEY_BITS)
        check($sformatf("chal_bit%0d", (k - 1) / P), puf_challenge, chal[(k - 1) / P]);
      if (k == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_key", key, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_chal", puf_challenge, 8'h00);
        check("rst_flags", {done, key_valid}, 2'b00);
        check("rst_unstable", unstable_cnt, '0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    check("done_seen", runs_checked, runs_pushed);
    check("busy_after_done", busy, 1'b0);
    check("done_pulse_width", done, 1'b0);
    check("key_valid_hold", key_valid, 1'b1);
    check("key_hold", key, e.key);
  endtask

  // Scoreboard monitor: compare the finished key against the queued model.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending run");
      end else begin
        e = exp_q.pop_front();
        check("done_edge", edge_cnt + 1 - accept_edge, e.done_edge);
        check("key", key, e.key);
        check("unstable_cnt", unstable_cnt, e.unstable);
        check("final_chal", puf_challenge, e.last_chal);
        check("busy_in_done", busy, 1'b1);
        check("key_valid_in_done", key_valid, 1'b1);
      end
      runs_checked <= runs_checked + 1;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_key", key, '0);
    check("reset_chal", puf_challenge, 8'h00);
    check("reset_unstable", unstable_cnt, '0);
    for (int i = 0; i < 20; i++) begin
      check("idle_outputs", {busy, done, key_valid}, 3'b000);
      @(negedge clk);
    end

    run(8'h00, M_CONST1, 0, 0);
    run(8'hA5, M_PARITY, 0, 0);
    run(8'h5A, M_GLITCH, 0, 0);
    run(8'h11, M_PARITY, 50, 0);
    run(8'h77, M_RANDOM, 0, 100);
    run(8'h99, M_RANDOM, 0, 0);
    for (int r = 0; r < 4; r++) run(8'($urandom_range(0, 255)), M_RANDOM, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_key_sequencer.md
# puf_key_sequencer

Sequencer that turns the 8-bit-challenge / 1-bit-response SimplePUF into a multi-bit device key. On `start` it walks an LFSR-generated challenge sequence, waits for the PUF to settle, majority-votes repeated response samples, and shifts each voted bit into a key register. It sits between the SimplePUF instance and the key consumer, and reports how many bits were unstable during voting.

## Interface
- `KEY_BITS`, 32, number of key bits generated per run (2..64)
- `SETTLE`, 2, cycles the challenge is held before sampling begins (≥1)
- `VOTES`, 3, response samples per bit; must be odd, ≥1
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a run; sampled only in IDLE
- `seed`  in  8  initial challenge; 8'h00 is replaced by 8'h01
- `puf_response`  in  1  response bit from the SimplePUF
- `puf_challenge`  out  8  challenge driven to the SimplePUF
- `busy`  out  1  high from the cycle after `start` is accepted until the DONE cycle, inclusive
- `done`  out  1  one-cycle pulse when the key is complete
- `key`  out  KEY_BITS  generated key; the first bit lands in the MSB
- `key_valid`  out  1  high from `done` until the next accepted `start` or `rst`
- `unstable_cnt`  out  $clog2(KEY_BITS+1)  number of bits whose votes were not unanimous

## Operation
- States:
  - IDLE: waits for `start`. On accept: challenge ← seed (8'h01 if seed==0), bit_cnt ← 0, key ← 0, unstable_cnt ← 0, key_valid ← 0; go to SETTLE.
  - SETTLE: holds the challenge for `SETTLE` cycles, then goes to SAMPLE with ones_cnt ← 0.
  - SAMPLE: runs for `VOTES` cycles; ones_cnt increments when `puf_response` is 1.
  - SHIFT: one cycle.
    - vote = (ones_cnt > VOTES/2); key ← {key[KEY_BITS-2:0], vote}.
    - If ones_cnt is neither 0 nor VOTES, unstable_cnt increments.
    - challenge ← lfsr_next(challenge); bit_cnt increments.
    - If bit_cnt reaches KEY_BITS-1 on this cycle, go to DONE; otherwise go to SETTLE.
  - DONE: `done`=1 and `key_valid` ← 1; go to IDLE.
- LFSR is 8-bit Fibonacci, left shift: next = {c[6:0], c[7]^c[5]^c[4]^c[3]}. Maximal length, never reaches 0.
- `start` in any state other than IDLE is ignored. The run continues unaffected.
- `start` held high through DONE→IDLE re-arms on the first IDLE cycle.
- The final challenge is left on `puf_challenge` after the run. `key` and `unstable_cnt` hold until the next accepted start.
- `ones_cnt` width is $clog2(VOTES+1). `unstable_cnt` saturates by construction at KEY_BITS.

## Timing
- Reset values: state=IDLE, `puf_challenge`=8'h00, `busy`=0, `done`=0, `key`=0, `key_valid`=0, `unstable_cnt`=0.
- `rst` mid-run returns every output to its reset value on the next edge. No partial key remains visible.
- The first challenge appears on `puf_challenge` in the cycle after the `start` edge.
- Cycles per bit = SETTLE + VOTES + 1 (6 with defaults).
- `done` is high 1 + KEY_BITS·(SETTLE+VOTES+1) edges after the edge that accepts `start` (193 with defaults).
- Response sampling is registered: the SAMPLE cycles use `puf_response` as seen at each clock edge while in SAMPLE.
- `busy` drops in the cycle after `done`. A new `start` can be accepted in that same cycle.

## Structure
- Package `puf_pkg` holds:
  - the state enum (IDLE, SETTLE, SAMPLE, SHIFT, DONE)
  - `PUF_CHAL_W`=8
  - the LFSR tap constant
  - the zero-seed substitute 8'h01
- Sub-module `puf_lfsr8`: combinational next-state function, also reused by the bench model.
- Top level contains the FSM, counters, vote logic and key shift register.

## Test plan
- Reset then idle: hold `rst` for 2 cycles, no `start` → all outputs 0, `busy`=0 for 20 cycles.
- Constant-1 PUF model: seed=8'h00 → `puf_challenge`=8'h01 one cycle after start, 8'h02 at bit 1; `done` at edge 193; `key`=32'hFFFF_FFFF, `unstable_cnt`=0.
- Parity PUF (response = ^challenge), seed=8'hA5 → key matches a bench model built on `puf_lfsr8`, MSB first; `key_valid`=1 after `done`, cleared on the next start.
- Glitch voting: force the response to 1 for exactly one SAMPLE cycle of every bit, 0 otherwise → `key`=0, `unstable_cnt`=32.
- Start while busy: pulse `start` with seed 8'h3C at cycle 50 of a run seeded 8'h11 → run completes with the 8'h11 sequence and `done` still at edge 193.
- Reset mid-run: assert `rst` at cycle 100 → next cycle `key`=0, `busy`=0, `puf_challenge`=8'h00; a fresh start then runs to completion normally.
